// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter (instruction fetch / data access) for
//                a shared single-port memory with a fixed access latency.
//                Each granted access holds the memory for LATENCY cycles. It
//                then pulses the requester's Done with registered read data.
//                Optional macro MEM_ARBITER_ROUND_ROBIN_EN switches tie
//                resolution from fixed DATA priority to round robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          FetchReq,
    input  logic [AW-1:0] FetchAddr,
    output logic          FetchDone,
    output logic [31:0]   FetchData,
    input  logic          DataReq,
    input  logic          DataWrite,
    input  logic [AW-1:0] DataAddr,
    input  logic [31:0]   DataWData,
    output logic          DataDone,
    output logic [31:0]   DataRData,
    output logic          StallF,
    output logic          StallM,
    output logic          MemEn,
    output logic          MemWE,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWData,
    input  logic [31:0]   MemRData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fetch_done_q, fetch_done_d;
    logic        data_done_q, data_done_d;
    logic [31:0] fetch_data_q, fetch_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic        w_fetch_elig;
    logic        w_data_elig;
    logic        w_grant_data;

    // A requester whose Done is pulsing this cycle is not re-granted yet.
    assign w_fetch_elig = FetchReq & ~fetch_done_q;
    assign w_data_elig  = DataReq  & ~data_done_q;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;   // 1 = DATA was served last

    // On a tie, serve the requester that did not win last time.
    assign w_grant_data = w_data_elig & (~w_fetch_elig | ~last_data_q);

    // Remember the winner of every grant made from IDLE.
    always_comb begin
        last_data_d = last_data_q;
        if (state_q == ST_IDLE && (w_data_elig || w_fetch_elig)) begin
            last_data_d = w_grant_data;
        end
    end

    // Last-grant register, resets to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    // Fixed priority: the older instruction (memory stage) drains first.
    assign w_grant_data = w_data_elig;
`endif

    // Next-state, latency counter and read-data capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_data) begin
                    state_d = ST_DATA;
                    cnt_d   = C_CNT_LOAD;
                end else if (w_fetch_elig) begin
                    state_d = ST_FETCH;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            ST_FETCH: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_IDLE;
                    fetch_done_d = 1'b1;
                    fetch_data_d = MemRData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    data_done_d = 1'b1;
                    if (!DataWrite) begin
                        data_rdata_d = MemRData;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, Done pulses and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            fetch_data_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Memory port follows the granted requester; all zero while idle.
    always_comb begin
        MemEn    = 1'b0;
        MemWE    = 1'b0;
        MemAddr  = '0;
        MemWData = 32'd0;
        case (state_q)
            ST_FETCH: begin
                MemEn   = 1'b1;
                MemAddr = FetchAddr;
            end
            ST_DATA: begin
                MemEn    = 1'b1;
                MemWE    = DataWrite;
                MemAddr  = DataAddr;
                MemWData = DataWData;
            end
            default: begin
                MemEn = 1'b0;
            end
        endcase
    end

    assign FetchDone = fetch_done_q;
    assign FetchData = fetch_data_q;
    assign DataDone  = data_done_q;
    assign DataRData = data_rdata_q;
    assign StallF    = FetchReq & ~fetch_done_q;
    assign StallM    = DataReq  & ~data_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Expected Done events are
//                scheduled from the arbitration rules and queued at stimulus
//                time. A negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 2;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        FetchReq = 1'b0;
    logic [31:0] FetchAddr = 32'd0;
    logic        DataReq = 1'b0;
    logic        DataWrite = 1'b0;
    logic [31:0] DataAddr = 32'd0;
    logic [31:0] DataWData = 32'd0;
    logic        FetchDone, DataDone, StallF, StallM, MemEn, MemWE;
    logic [31:0] FetchData, DataRData, MemAddr, MemWData, MemRData;

    mem_arbiter #(.LATENCY(LAT), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .FetchReq  (FetchReq),
        .FetchAddr (FetchAddr),
        .FetchDone (FetchDone),
        .FetchData (FetchData),
        .DataReq   (DataReq),
        .DataWrite (DataWrite),
        .DataAddr  (DataAddr),
        .DataWData (DataWData),
        .DataDone  (DataDone),
        .DataRData (DataRData),
        .StallF    (StallF),
        .StallM    (StallM),
        .MemEn     (MemEn),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C220004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign MemRData = mem_fn(MemAddr);

    typedef struct {
        int          cyc;
        bit          is_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          we_cycles = 0;
    logic [31:0] exp_last_load = 32'd0;
    bit          last_data_served = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_done(input bit is_data, input logic [31:0] val);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: %s Done at cycle %0d, none expected",
                     is_data ? "Data" : "Fetch", cyc);
        end else begin
            e = sbq.pop_front();
            if (e.is_data != is_data || e.cyc != cyc || e.data !== val) begin
                errors++;
                $display("FAIL done_event: got %s cyc=%0d data=%h expected %s cyc=%0d data=%h",
                         is_data ? "Data" : "Fetch", cyc, val,
                         e.is_data ? "Data" : "Fetch", e.cyc, e.data);
            end
        end
    endtask

    // Monitor: interface invariants every cycle plus scoreboard on Done.
    always @(negedge clk) begin
        if (!reset) begin
            chk("stallF", {63'd0, StallF}, {63'd0, FetchReq & ~FetchDone});
            chk("stallM", {63'd0, StallM}, {63'd0, DataReq & ~DataDone});
            if (MemEn !== 1'b1) begin
                chk("idle_mem_zero", {MemWE, MemAddr, MemWData[30:0]}, 64'd0);
            end
            if (MemWE === 1'b1) begin
                we_cycles++;
                chk("store_port", {MemAddr, MemWData}, {DataAddr, DataWData});
            end
            if (FetchDone === 1'b1) check_done(1'b0, FetchData);
            if (DataDone === 1'b1) check_done(1'b1, DataRData);
        end
    end

    task automatic fetch_agent(input int off, input logic [31:0] a);
        int n;
        repeat (off) begin @(posedge clk); #1; end
        FetchReq  = 1'b1;
        FetchAddr = a;
        n = 0;
        @(negedge clk);
        while (FetchDone !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("fetch_done_seen", {63'd0, FetchDone}, 64'd1);
        @(posedge clk); #1;
        FetchReq = 1'b0;
    endtask

    task automatic data_agent(input int off, input logic [31:0] a, input bit wr,
                              input logic [31:0] wd, input bit drop_early);
        int n;
        repeat (off) begin @(posedge clk); #1; end
        DataReq   = 1'b1;
        DataAddr  = a;
        DataWrite = wr;
        DataWData = wd;
        n = 0;
        if (drop_early) begin
            @(posedge clk); #1;
            DataReq = 1'b0;
        end
        @(negedge clk);
        while (DataDone !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("data_done_seen", {63'd0, DataDone}, 64'd1);
        @(posedge clk); #1;
        DataReq = 1'b0;
    endtask

    function automatic exp_t mk(input int c, input bit d, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.is_data = d; e.data = v;
        return e;
    endfunction

    // Expected response of a data access; loads update the model's last load.
    function automatic logic [31:0] data_result(input logic [31:0] a, input bit wr);
        if (!wr) exp_last_load = mem_fn(a);
        return exp_last_load;
    endfunction

    // One transaction round from a quiet arbiter. The schedule is computed
    // from arrival times: earlier arrival wins, ties follow the tie rule,
    // and a waiting requester is granted in the holder's Done cycle.
    task automatic run_round(input bit use_f, input bit use_d, input int off_f, input int off_d,
                             input logic [31:0] fa, input logic [31:0] da, input bit wr,
                             input logic [31:0] wd, input bit drop_d_early);
        int t0, tf, td, t1, t2, d1, d2;
        bit data_first;
        exp_t ef, ed;
        @(posedge clk); #1;
        t0 = cyc;
        tf = t0 + off_f;
        td = t0 + off_d;
        we_cycles = 0;
        if (use_f && use_d) begin
            if (td < tf)      data_first = 1'b1;
            else if (tf < td) data_first = 1'b0;
            else              data_first = RR ? !last_data_served : 1'b1;
            t1 = data_first ? td : tf;
            t2 = data_first ? tf : td;
            d1 = t1 + LAT + 1;
            d2 = ((t2 > d1) ? t2 : d1) + LAT + 1;
            ef = mk(data_first ? d2 : d1, 1'b0, mem_fn(fa));
            ed = mk(data_first ? d1 : d2, 1'b1, data_result(da, wr));
            if (data_first) begin sbq.push_back(ed); sbq.push_back(ef); end
            else            begin sbq.push_back(ef); sbq.push_back(ed); end
            last_data_served = !data_first;
        end else if (use_d) begin
            sbq.push_back(mk(td + LAT + 1, 1'b1, data_result(da, wr)));
            last_data_served = 1'b1;
        end else begin
            sbq.push_back(mk(tf + LAT + 1, 1'b0, mem_fn(fa)));
            last_data_served = 1'b0;
        end
        fork
            begin if (use_f) fetch_agent(off_f, fa); end
            begin if (use_d) data_agent(off_d, da, wr, wd, drop_d_early); end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("store_we_cycles", 64'(we_cycles), (use_d && wr) ? 64'(LAT) : 64'd0);
    endtask

    // Reset while a load sits at its final counter cycle.
    task automatic reset_mid_load(input logic [31:0] a);
        int t, c, n;
        @(posedge clk); #1;
        t = cyc;
        DataReq = 1'b1; DataWrite = 1'b0; DataAddr = a; DataWData = 32'h0;
        while (cyc < t + LAT) begin @(posedge clk); #1; end
        chk("pre_reset_memen", {63'd0, MemEn}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem", {MemEn, MemWE, MemAddr, MemWData[29:0]}, 64'd0);
        chk("rst_async_done", {62'd0, DataDone, FetchDone}, 64'd0);
        chk("rst_async_rdata", {FetchData, DataRData}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        c = cyc;
        exp_last_load = 32'd0;
        sbq.push_back(mk(c + LAT + 1, 1'b1, data_result(a, 1'b0)));
        last_data_served = 1'b1;
        n = 0;
        @(negedge clk);
        while (DataDone !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("reset_regrant_done", {63'd0, DataDone}, 64'd1);
        @(posedge clk); #1;
        DataReq = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int mode, of, od;
        #1 reset = 1'b1;
        #1;
        chk("reset_done", {62'd0, FetchDone, DataDone}, 64'd0);
        chk("reset_rdata", {FetchData, DataRData}, 64'd0);
        chk("reset_mem", {MemEn, MemWE, MemAddr, MemWData[29:0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_round(1, 0, 0, 0, 32'h40, 32'h0, 0, 32'h0, 0);                // fetch 0x40
        run_round(0, 1, 0, 0, 32'h0, 32'h100, 1, 32'hDEADBEEF, 0);        // store
        run_round(0, 1, 0, 0, 32'h0, 32'h200, 0, 32'h0, 0);               // load
        run_round(0, 1, 0, 0, 32'h0, 32'h104, 1, 32'h12345678, 0);        // store keeps rdata
        run_round(1, 1, 0, 0, 32'h44, 32'h208, 0, 32'h0, 0);              // tie
        run_round(1, 1, 0, 0, 32'h48, 32'h20C, 1, 32'hCAFEF00D, 0);       // tie again
        run_round(1, 1, 1, 0, 32'h4C, 32'h210, 0, 32'h0, 0);              // data holds, fetch waits
        run_round(1, 1, 0, LAT + 1, 32'h50, 32'h214, 0, 32'h0, 0);        // data arrives at Done
        run_round(0, 1, 0, 0, 32'h0, 32'h300, 0, 32'h0, 1);               // early drop
        reset_mid_load(32'h400);

        for (int r = 0; r < 60; r++) begin
            mode = $urandom_range(0, 2);
            of   = $urandom_range(0, LAT + 3);
            od   = ($urandom_range(0, 1) == 1) ? of : $urandom_range(0, LAT + 3);
            run_round(mode != 1, mode != 0, of, od, $urandom & 32'hFFFC, $urandom & 32'hFFFC,
                      $urandom_range(0, 1) == 1, $urandom, 0);
        end

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
